// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-level CSR file and trap sequencer fed by the stage-6
// commit outputs. Holds privilege mode, mstatus/mie/mtvec/mscratch/xepc/mcause,
// the 64-bit cycle and instret counters, serves combinational CSR reads and
// drives a registered one-cycle fetch redirect on traps and xRETs.
// Ports:
//   clk, nrst                    clock, asynchronous active-low reset
//   exception, cause6, pc6       stage-6 trap/return request, cause, PC
//   mret6, sret6, uret6          xRET flavour (exception is also high)
//   csr_we6, csr_wb_addr, csr_wb stage-6 CSR write
//   retire6                      instruction retires this cycle
//   m_ext_irq, m_timer_irq       raw interrupt lines shown in mip
//   csr_raddr, csr_rdata         combinational CSR read port
//   current_mode                 privilege mode (11 M, 01 S, 00 U)
//   m_tie..u_sie                 mie bits gated by the matching mstatus xIE
//   redirect_valid, redirect_pc  registered redirect pulse and target
module csr_trap_unit #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        exception,
   input  logic [31:0] cause6,
   input  logic [31:0] pc6,
   input  logic        csr_we6,
   input  logic [11:0] csr_wb_addr,
   input  logic [31:0] csr_wb,
   input  logic        mret6,
   input  logic        sret6,
   input  logic        uret6,
   input  logic        retire6,
   input  logic        m_ext_irq,
   input  logic        m_timer_irq,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic [1:0]  current_mode,
   output logic        m_tie,
   output logic        m_eie,
   output logic        s_tie,
   output logic        s_eie,
   output logic        u_tie,
   output logic        u_eie,
   output logic        u_sie,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CLEN = 64;

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_SEPC     = 12'h141;
   localparam logic [11:0] ADDR_UEPC     = 12'h041;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
   localparam logic [11:0] ADDR_INSTRET  = 12'hC02;

   localparam logic [XLEN-1:0] MSTATUS_MASK = 32'h0000_19BB;
   localparam logic [XLEN-1:0] MIE_MASK     = 32'h0000_0BB1;
   localparam logic [1:0]      MODE_M       = 2'b11;

   localparam int unsigned UIE_B  = 0;
   localparam int unsigned SIE_B  = 1;
   localparam int unsigned MIE_B  = 3;
   localparam int unsigned UPIE_B = 4;
   localparam int unsigned SPIE_B = 5;
   localparam int unsigned MPIE_B = 7;
   localparam int unsigned SPP_B  = 8;
   localparam int unsigned MPP_LO = 11;
   localparam int unsigned MPP_HI = 12;

   logic [1:0]      mode_q, mode_d;
   logic [XLEN-1:0] mstatus_q, mstatus_d;
   logic [XLEN-1:0] mie_q, mie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] sepc_q, sepc_d;
   logic [XLEN-1:0] uepc_q, uepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [CLEN-1:0] mcycle_q, mcycle_d;
   logic [CLEN-1:0] minstret_q, minstret_d;
   logic            redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_d;
   logic [XLEN-1:0] tvec_base;
   logic [XLEN-1:0] trap_pc;
   logic [XLEN-1:0] mip;

   // Vectored mode offsets only interrupts; synchronous traps use the base.
   assign tvec_base = mtvec_q & ~32'd3;
   assign trap_pc   = (mtvec_q[0] && cause6[31])
                      ? tvec_base + (XLEN'(cause6[4:0]) << 2)
                      : tvec_base;

   assign mip = (XLEN'(m_ext_irq) << 11) | (XLEN'(m_timer_irq) << 7);

   // Next-state: trap/xRET beats CSR write, CSR write beats counter increment.
   always_comb begin : next_state
      mode_d           = mode_q;
      mstatus_d        = mstatus_q;
      mie_d            = mie_q;
      mtvec_d          = mtvec_q;
      mscratch_d       = mscratch_q;
      mepc_d           = mepc_q;
      sepc_d           = sepc_q;
      uepc_d           = uepc_q;
      mcause_d         = mcause_q;
      mcycle_d         = mcycle_q + 64'd1;
      minstret_d       = minstret_q + CLEN'(retire6 & ~exception);
      redirect_valid_d = exception;
      redirect_pc_d    = redirect_pc;

      if (exception) begin
         if (mret6) begin
            redirect_pc_d               = mepc_q;
            mode_d                      = mstatus_q[MPP_HI:MPP_LO];
            mstatus_d[MIE_B]            = mstatus_q[MPIE_B];
            mstatus_d[MPIE_B]           = 1'b1;
            mstatus_d[MPP_HI:MPP_LO]    = 2'b00;
         end else if (sret6) begin
            redirect_pc_d               = sepc_q;
            mode_d                      = {1'b0, mstatus_q[SPP_B]};
            mstatus_d[SIE_B]            = mstatus_q[SPIE_B];
            mstatus_d[SPIE_B]           = 1'b1;
            mstatus_d[SPP_B]            = 1'b0;
         end else if (uret6) begin
            redirect_pc_d               = uepc_q;
            mode_d                      = 2'b00;
            mstatus_d[UIE_B]            = mstatus_q[UPIE_B];
            mstatus_d[UPIE_B]           = 1'b1;
         end else begin
            redirect_pc_d               = trap_pc;
            mepc_d                      = pc6 & ~32'd3;
            mcause_d                    = cause6;
            mstatus_d[MPIE_B]           = mstatus_q[MIE_B];
            mstatus_d[MIE_B]            = 1'b0;
            mstatus_d[MPP_HI:MPP_LO]    = mode_q;
            mode_d                      = MODE_M;
         end
      end else if (csr_we6) begin
         case (csr_wb_addr)
            ADDR_MSTATUS:  mstatus_d             = csr_wb & MSTATUS_MASK;
            ADDR_MIE:      mie_d                 = csr_wb & MIE_MASK;
            ADDR_MTVEC:    mtvec_d               = csr_wb & ~32'd2;
            ADDR_MSCRATCH: mscratch_d            = csr_wb;
            ADDR_MEPC:     mepc_d                = csr_wb & ~32'd3;
            ADDR_SEPC:     sepc_d                = csr_wb & ~32'd3;
            ADDR_UEPC:     uepc_d                = csr_wb & ~32'd3;
            ADDR_MCAUSE:   mcause_d              = csr_wb;
            ADDR_MCYCLE:   mcycle_d[31:0]        = csr_wb;
            ADDR_MCYCLEH:  mcycle_d[63:32]       = csr_wb;
            ADDR_MINSTRET: minstret_d[31:0]      = csr_wb;
            ADDR_MINSTRH:  minstret_d[63:32]     = csr_wb;
            default: ;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge nrst) begin : state_reg
      if (!nrst) begin
         mode_q         <= MODE_M;
         mstatus_q      <= '0;
         mie_q          <= '0;
         mtvec_q        <= MTVEC_RESET;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         sepc_q         <= '0;
         uepc_q         <= '0;
         mcause_q       <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         mode_q         <= mode_d;
         mstatus_q      <= mstatus_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         sepc_q         <= sepc_d;
         uepc_q         <= uepc_d;
         mcause_q       <= mcause_d;
         mcycle_q       <= mcycle_d;
         minstret_q     <= minstret_d;
         redirect_valid <= redirect_valid_d;
         redirect_pc    <= redirect_pc_d;
      end
   end

   // Combinational read port; no bypass of same-cycle writes.
   always_comb begin : csr_read
      csr_rdata = '0;
      case (csr_raddr)
         ADDR_MSTATUS:              csr_rdata = mstatus_q;
         ADDR_MIE:                  csr_rdata = mie_q;
         ADDR_MTVEC:                csr_rdata = mtvec_q;
         ADDR_MSCRATCH:             csr_rdata = mscratch_q;
         ADDR_MEPC:                 csr_rdata = mepc_q;
         ADDR_SEPC:                 csr_rdata = sepc_q;
         ADDR_UEPC:                 csr_rdata = uepc_q;
         ADDR_MCAUSE:               csr_rdata = mcause_q;
         ADDR_MIP:                  csr_rdata = mip;
         ADDR_MCYCLE, ADDR_CYCLE:   csr_rdata = mcycle_q[31:0];
         ADDR_MCYCLEH:              csr_rdata = mcycle_q[63:32];
         ADDR_MINSTRET, ADDR_INSTRET: csr_rdata = minstret_q[31:0];
         ADDR_MINSTRH:              csr_rdata = minstret_q[63:32];
         default:                   csr_rdata = '0;
      endcase
   end

   assign current_mode = mode_q;
   assign m_tie = mie_q[7]  & mstatus_q[MIE_B];
   assign m_eie = mie_q[11] & mstatus_q[MIE_B];
   assign s_tie = mie_q[5]  & mstatus_q[SIE_B];
   assign s_eie = mie_q[9]  & mstatus_q[SIE_B];
   assign u_tie = mie_q[4]  & mstatus_q[UIE_B];
   assign u_eie = mie_q[8]  & mstatus_q[UIE_B];
   assign u_sie = mie_q[0]  & mstatus_q[UIE_B];

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-level CSR file and trap sequencer that consumes the stage-6 commit outputs of the execute stage (exception, cause6, pc6, csr_we6/csr_wb_addr/csr_wb, mret6/sret6/uret6). It holds the privilege mode, the status, enable, vector, epc and cause registers, and the cycle/instret counters. It serves combinational CSR reads to the issue path and drives a registered fetch redirect on traps and returns. All traps go to M-mode; there is no delegation.

## Interface
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec
- clk  in  1  clock
- nrst  in  1  asynchronous, active-low reset
- exception  in  1  trap/return pending this cycle (stage 6)
- cause6  in  32  trap cause; bit31 = interrupt
- pc6  in  32  PC of the stage-6 instruction
- csr_we6  in  1  CSR write strobe
- csr_wb_addr  in  12  CSR write address
- csr_wb  in  32  CSR write data
- mret6, sret6, uret6  in  1  xRET in stage 6 (these also assert exception)
- retire6  in  1  instruction retires this cycle
- m_ext_irq, m_timer_irq  in  1  raw interrupt lines, reflected in mip
- csr_raddr  in  12  read address from stage 4
- csr_rdata  out  32  read data, combinational from csr_raddr
- current_mode  out  2  privilege mode: 11 M, 01 S, 00 U
- m_tie, m_eie, s_tie, s_eie, u_tie, u_eie, u_sie  out  1  gated enables, equal to mie bit AND the matching mstatus xIE
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  redirect target

## Operation
- Implemented CSRs:
  - mstatus 0x300: UIE0, SIE1, MIE3, UPIE4, SPIE5, MPIE7, SPP8, MPP12:11; all other bits read 0.
  - mie 0x304: USIE0, UTIE4, STIE5, MTIE7, UEIE8, SEIE9, MEIE11.
  - mtvec 0x305: bit1 forced 0; mode = bit0, 0 direct, 1 vectored.
  - mscratch 0x340.
  - mepc 0x341, sepc 0x141, uepc 0x041: bits1:0 forced 0.
  - mcause 0x342.
  - mip 0x344: read-only; MEIP11 = m_ext_irq, MTIP7 = m_timer_irq.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82; cycle/instret 0xC00/0xC02 are read-only mirrors of the low words.
- Unimplemented addresses read 0; writes to them are ignored.
- Trap, when exception=1 and no xRET flag is set:
  - mepc ← pc6 & ~3.
  - mcause ← cause6.
  - MPIE ← MIE; MIE ← 0; MPP ← current_mode; mode ← M.
  - Redirect target: mtvec&~3 in direct mode. In vectored mode with cause6[31]=1, target is (mtvec&~3) + 4·cause6[4:0].
- mret6: redirect to mepc; mode ← MPP; MIE ← MPIE; MPIE ← 1; MPP ← 00.
- sret6: redirect to sepc; mode ← {0,SPP}; SIE ← SPIE; SPIE ← 1; SPP ← 0.
- uret6: redirect to uepc; mode ← 00; UIE ← UPIE; UPIE ← 1.
- Priority in one cycle: trap/xRET first, then csr_we6, then counter increment.
  - While exception=1, csr_we6 and retire6 are ignored.
  - A CSR write to a counter word replaces that cycle's increment of that word.
- Counters:
  - mcycle (64-bit) +1 every cycle.
  - minstret (64-bit) +1 when retire6=1.
  - Both wrap from 2^64−1 to 0; the carry crosses into the high word in the same cycle.
- There is no read bypass: a read in the same cycle as a write to the same CSR returns the old value.

## Timing
- Reset values:
  - current_mode = 11; mstatus = mie = mscratch = mepc = sepc = uepc = mcause = 0; mtvec = MTVEC_RESET; counters = 0.
  - redirect_valid = 0, redirect_pc = 0; all gated enables 0.
- All CSR and mode updates take effect at the clk edge that samples exception/csr_we6.
- Redirect:
  - redirect_valid/redirect_pc are registered and appear in the cycle after exception=1.
  - The pulse lasts exactly 1 cycle unless exception stays high.
  - Consecutive exception cycles (for example a held interrupt) produce one trap per cycle; each overwrites mepc/mcause.
- csr_rdata and the gated enables are combinational from the current registers, so updated enables are visible the cycle after the write.
- A reset asserted mid-trap clears redirect_valid asynchronously; no partial state persists.

## Test plan
- Reset release, csr_raddr=0x305 → csr_rdata=0x100, current_mode=11, redirect_valid=0 for all cycles with no stimulus.
- csr_we6, addr 0x300, data 0x88, then 0x304 ← 0x80 → next cycle m_tie=1; mstatus read = 0x88 (MIE and MPIE set).
- Trap: exception=1, cause6=0x8000_0007, pc6=0x204, mtvec=0x101 → one cycle later redirect_pc=0x11C, redirect_valid=1 for 1 cycle; mepc=0x204, mcause=0x8000_0007, MIE=0, MPIE=1, MPP=11.
- mret with MPP=00, mepc=0x300 → redirect_pc=0x300, current_mode=00, MIE=MPIE, MPP=00.
- exception=1 with csr_we6=1 to mscratch (0xDEAD) → mscratch unchanged; retire6 is not counted.
- mcycle written to 0xFFFF_FFFF, then read 0xB80 after one more cycle → mcycleh increments by 1 and mcycle=0; a mcycle write with 5 → next-cycle read returns 6.
